// File: rtl/mealy_nol_pkg.sv
// Shared types and constants for the non-overlapping 101010 Mealy detector.
package mealy_nol_pkg;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } state_e;

    localparam logic [5:0] PATTERN = 6'b101010;

    // Bit that extends the prefix held in state s (first pattern bit is PATTERN[5]).
    function automatic logic expected_bit(input state_e s);
        return PATTERN[3'd5 - 3'(s)];
    endfunction

endpackage

// File: rtl/mealy_nol.sv
// Mealy serial detector for 101010, non-overlapping, with a combinational match flag.
// Optional saturating detection counter enabled by defining MEALY_NOL_MATCH_CNT_EN.
//
// state | meaning
// S0    | idle, no prefix matched
// S1    | "1"
// S2    | "10"
// S3    | "101"
// S4    | "1010"
// S5    | "10101"
module mealy_nol
    import mealy_nol_pkg::*;
`ifdef MEALY_NOL_MATCH_CNT_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
`ifdef MEALY_NOL_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             out
);

    state_e state_q;
    state_e state_d;

    // On a mismatch the only prefix that can survive is a lone "1", so the
    // fallback depends on the input bit alone.
    always_comb begin
        state_d = S0;
        if (in == expected_bit(state_q)) begin
            state_d = (state_q == S5) ? S0 : state_e'(state_q + 3'd1);
        end else begin
            state_d = in ? S1 : S0;
        end
    end

    assign out = (state_q == S5) && !in && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef MEALY_NOL_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_q <= '0;
        end else if (out && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_q <= match_cnt_q + 1'b1;
        end
    end

    assign match_cnt = match_cnt_q;
`endif

endmodule

// File: tb/tb_mealy_nol.sv
// Self-checking bench for mealy_nol: directed vector table, random stream vs. a
// history-based reference, and (with MEALY_NOL_MATCH_CNT_EN) counter saturation.
module tb_mealy_nol;

    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic in;
    logic out;
`ifdef MEALY_NOL_MATCH_CNT_EN
    logic [TB_CNT_W-1:0] match_cnt;
`endif

    always #5 clk = ~clk;

`ifdef MEALY_NOL_MATCH_CNT_EN
    mealy_nol #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .in(in), .match_cnt(match_cnt), .out(out)
    );
`else
    mealy_nol dut (
        .clk(clk), .rst(rst), .in(in), .out(out)
    );
`endif

    typedef struct {
        logic  r;
        logic  b;
        logic  exp_out;
        string name;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ref_cnt = 0;
    bit   cnt_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input string bits_s, input string exps, input string name);
        for (int i = 0; i < bits_s.len(); i++) begin
            vec_t v;
            v.r       = r;
            v.b       = (bits_s[i] == "1");
            v.exp_out = (exps[i] == "1");
            v.name    = name;
            vecs.push_back(v);
        end
    endtask

    // Drives one bit mid-cycle, checks the Mealy flag before the consuming edge.
    task automatic step(input logic r, input logic b, input logic exp_out, input string name);
        @(negedge clk);
`ifdef MEALY_NOL_MATCH_CNT_EN
        if (cnt_valid) chk({name, "/match_cnt"}, int'(match_cnt), ref_cnt);
`endif
        rst = r;
        in  = b;
        #1;
        if (out === 1'bx || out === 1'bz) chk({name, "/out_known"}, 0, 1);
        else chk({name, "/out"}, int'(out), int'(exp_out));
        if (r) begin
            ref_cnt   = 0;
            cnt_valid = 1'b1;
        end else if (exp_out && ref_cnt < CNT_MAX) begin
            ref_cnt++;
        end
    endtask

    // Reference: remember bits since the last reset or detection; a detection
    // happens when the most recent six equal the pattern, then history is dropped.
    logic hist[$];
    localparam logic [5:0] PAT = 6'b101010;

    function automatic logic model_step(input logic r, input logic b);
        logic hit;
        hit = 1'b0;
        if (r) begin
            hist.delete();
        end else begin
            hist.push_back(b);
            if (hist.size() > 6) void'(hist.pop_front());
            if (hist.size() == 6) begin
                hit = 1'b1;
                for (int k = 0; k < 6; k++) if (hist[k] != PAT[5-k]) hit = 1'b0;
                if (hit) hist.delete();
            end
        end
        return hit;
    endfunction

    initial begin
        int det_seen;
        rst = 1'b1;
        in  = 1'b0;

        add(1, "10",           "00",           "reset_idle");
        add(0, "101010",       "000001",       "single");
        add(0, "10101010",     "00000100",     "nonoverlap8");
        add(0, "1010",         "0001",         "left_in_s2");
        add(1, "1",            "0",            "rst");
        add(0, "101010101010", "000001000001", "double");
        add(1, "0",            "0",            "rst");
        add(0, "1101010",      "0000001",      "s1_selfloop");
        add(1, "0",            "0",            "rst");
        add(0, "10101101010",  "00000000001",  "s5_to_s1");
        add(1, "0",            "0",            "rst");
        add(0, "10101",        "00000",        "partial");
        add(1, "0",            "0",            "rst_in_s5");
        add(0, "0",            "0",            "after_rst_0");
        add(0, "101010",       "000001",       "fresh");
        add(0, "000111",       "000000",       "no_match");

        foreach (vecs[i]) step(vecs[i].r, vecs[i].b, vecs[i].exp_out, vecs[i].name);

        // Random stream with occasional resets against the history model.
        step(1, 1'b0, 1'b0, "rand_rst");
        hist.delete();
        det_seen = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r, b, e;
            r = ($urandom_range(0, 99) == 0);
            b = 1'($urandom_range(0, 1));
            e = model_step(r, b);
            if (e) det_seen++;
            step(r, b, e, "random");
        end
        chk("random_detections_seen", int'(det_seen > 0), 1);

`ifdef MEALY_NOL_MATCH_CNT_EN
        begin
            int exp_cnt[5] = '{1, 2, 3, 3, 3};
            step(1, 1'b0, 1'b0, "cnt_rst");
            for (int p = 0; p < 5; p++) begin
                for (int k = 0; k < 6; k++) step(0, PAT[5-k], (k == 5), "cnt_pat");
                @(negedge clk);
                chk("match_cnt_sat", int'(match_cnt), exp_cnt[p]);
            end
            step(1, 1'b0, 1'b0, "cnt_clear");
            @(negedge clk);
            chk("match_cnt_cleared", int'(match_cnt), 0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
